// File: rtl/adsr_envelope.sv
// adsr_envelope: per-voice ADSR amplitude envelope.
// Steps an 8-bit level once per sample-rate strobe while tracking a note gate,
// and scales the 4-bit voice sample by that level for the PWM DAC.
//
// Ports:
//   clock      system clock
//   reset      asynchronous, active-high
//   ena        sample-rate strobe, one clock wide
//   gate       note held (1) / released (0), sampled on ena cycles
//   sample_in  unsigned 4-bit raw voice sample
//   sample_out unsigned 4-bit scaled sample, (sample_in * level) >> 8
//   level      current envelope level
//   state      IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
//   busy       high whenever state != IDLE
module adsr_envelope #(
  parameter int unsigned ATTACK_STEP   = 8,
  parameter int unsigned DECAY_STEP    = 2,
  parameter int unsigned SUSTAIN_LEVEL = 160,
  parameter int unsigned RELEASE_STEP  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ena,
  input  logic       gate,
  input  logic [3:0] sample_in,
  output logic [3:0] sample_out,
  output logic [7:0] level,
  output logic [2:0] state,
  output logic       busy
);

  localparam int unsigned LEVEL_W  = 8;
  localparam int unsigned SAMPLE_W = 4;
  localparam int unsigned PROD_W   = LEVEL_W + SAMPLE_W;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ATTACK  = 3'd1;
  localparam logic [2:0] S_DECAY   = 3'd2;
  localparam logic [2:0] S_SUSTAIN = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [LEVEL_W:0]   ATK_STEP9 = (LEVEL_W+1)'(ATTACK_STEP);
  localparam logic [LEVEL_W:0]   LEVEL_MAX = (LEVEL_W+1)'(255);
  localparam logic signed [9:0]  DEC_STEPS = 10'(DECAY_STEP);
  localparam logic signed [9:0]  SUS_S     = 10'(SUSTAIN_LEVEL);
  localparam logic [LEVEL_W-1:0] SUS_LVL   = LEVEL_W'(SUSTAIN_LEVEL);
  localparam logic [LEVEL_W-1:0] REL_STEP  = LEVEL_W'(RELEASE_STEP);

  logic                     gate_q;
  logic [2:0]               state_n;
  logic [LEVEL_W-1:0]       level_n;
  logic [LEVEL_W:0]         attack_sum;
  logic signed [9:0]        decay_diff;
  logic [PROD_W-1:0]        product;

  // State, level and gate history registers; sample_out is refreshed every clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      level      <= '0;
      gate_q     <= 1'b0;
      busy       <= 1'b0;
      sample_out <= '0;
    end else begin
      state      <= state_n;
      level      <= level_n;
      busy       <= (state_n != S_IDLE);
      sample_out <= product[PROD_W-1:LEVEL_W];
      if (ena) begin
        gate_q <= gate;
      end
    end
  end

  // 8x4 unsigned product; only the top nibble reaches the DAC.
  assign product = PROD_W'(level) * PROD_W'(sample_in);

  // Arithmetic kept one bit wider (attack) or signed (decay) so clamps see true overflow.
  assign attack_sum = {1'b0, level} + ATK_STEP9;
  assign decay_diff = $signed({2'b00, level}) - DEC_STEPS;

  // Next-state / next-level logic; everything holds outside strobe cycles.
  always_comb begin
    state_n = state;
    level_n = level;
    if (ena) begin
      if (gate && !gate_q) begin
        // Retrigger resumes attack from the current level.
        state_n = S_ATTACK;
      end else if (!gate && (state == S_ATTACK || state == S_DECAY ||
                             state == S_SUSTAIN)) begin
        state_n = S_RELEASE;
      end else begin
        case (state)
          S_IDLE: begin
            level_n = '0;
          end
          S_ATTACK: begin
            if (attack_sum >= LEVEL_MAX) begin
              level_n = LEVEL_MAX[LEVEL_W-1:0];
              state_n = S_DECAY;
            end else begin
              level_n = attack_sum[LEVEL_W-1:0];
            end
          end
          S_DECAY: begin
            if (level <= SUS_LVL) begin
              state_n = S_SUSTAIN;
            end else if (decay_diff <= SUS_S) begin
              level_n = SUS_LVL;
              state_n = S_SUSTAIN;
            end else begin
              level_n = decay_diff[LEVEL_W-1:0];
            end
          end
          S_SUSTAIN: begin
            level_n = level;
          end
          S_RELEASE: begin
            if (level <= REL_STEP) begin
              level_n = '0;
              state_n = S_IDLE;
            end else begin
              level_n = level - REL_STEP;
            end
          end
          default: begin
            level_n = '0;
            state_n = S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adsr_envelope.sv
module tb_adsr_envelope;

  localparam int ATK = 8;
  localparam int DEC = 2;
  localparam int SUS = 160;
  localparam int REL = 1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ena = 1'b0;
  logic       gate = 1'b0;
  logic [3:0] sample_in = 4'd0;
  logic [3:0] sample_out;
  logic [7:0] level;
  logic [2:0] state;
  logic       busy;

  adsr_envelope #(
    .ATTACK_STEP(ATK), .DECAY_STEP(DEC),
    .SUSTAIN_LEVEL(SUS), .RELEASE_STEP(REL)
  ) dut (
    .clock(clock), .reset(reset), .ena(ena), .gate(gate),
    .sample_in(sample_in), .sample_out(sample_out),
    .level(level), .state(state), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int st;
    int lv;
    int b;
    int so;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference envelope state
  int m_state = 0;
  int m_level = 0;
  bit m_gq = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_strobe(input bit g);
    if (g && !m_gq) m_state = 1;
    else if (!g && (m_state == 1 || m_state == 2 || m_state == 3)) m_state = 4;
    else begin
      case (m_state)
        0: m_level = 0;
        1: begin
          m_level = m_level + ATK;
          if (m_level >= 255) begin m_level = 255; m_state = 2; end
        end
        2: begin
          if (m_level <= SUS) m_state = 3;
          else begin
            m_level = m_level - DEC;
            if (m_level <= SUS) begin m_level = SUS; m_state = 3; end
          end
        end
        4: begin
          m_level = m_level - REL;
          if (m_level <= 0) begin m_level = 0; m_state = 0; end
        end
        default: ;
      endcase
    end
    m_gq = g;
  endfunction

  // One clock of stimulus, entered and left at the falling edge.
  task automatic tick(input bit e, input bit g, input logic [3:0] s);
    exp_t x;
    ena = e;
    gate = g;
    sample_in = s;
    x.so = (int'(s) * m_level) >> 8;
    if (e) model_strobe(g);
    x.st = m_state;
    x.lv = m_level;
    x.b  = (m_state != 0) ? 1 : 0;
    exp_q.push_back(x);
    @(negedge clock);
  endtask

  // Strobe followed by a non-strobe clock.
  task automatic strobe(input bit g, input logic [3:0] s);
    tick(1'b1, g, s);
    tick(1'b0, g, s);
  endtask

  // Scoreboard: compare every post-edge DUT output with the queued expectation.
  always @(posedge clock) begin
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check("state", int'(state), x.st);
      check("level", int'(level), x.lv);
      check("busy", int'(busy), x.b);
      check("sample_out", int'(sample_out), x.so);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, released mid-clock
    #3;
    check("rst_state", int'(state), 0);
    check("rst_level", int'(level), 0);
    check("rst_out", int'(sample_out), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 10; i++) strobe(1'b0, 4'd15);

    // Attack: first strobe only enters ATTACK
    strobe(1'b1, 4'd15);
    check("atk_enter_state", int'(state), 1);
    check("atk_enter_level", int'(level), 0);
    for (int i = 0; i < 31; i++) strobe(1'b1, 4'd15);
    check("atk_31_level", int'(level), 248);
    tick(1'b1, 1'b1, 4'd15);
    check("atk_top_level", int'(level), 255);
    check("atk_top_state", int'(state), 2);
    tick(1'b0, 1'b1, 4'd15);
    check("atk_top_out", int'(sample_out), 14);

    // Decay to sustain
    for (int i = 0; i < 48; i++) strobe(1'b1, 4'd15);
    check("sus_level", int'(level), 160);
    check("sus_state", int'(state), 3);
    check("sus_out", int'(sample_out), 9);
    for (int i = 0; i < 100; i++) strobe(1'b1, 4'($urandom_range(0, 15)));
    check("sus_hold", int'(level), 160);

    // Release to idle
    strobe(1'b0, 4'd15);
    check("rel_enter_state", int'(state), 4);
    check("rel_enter_level", int'(level), 160);
    for (int i = 0; i < 160; i++) strobe(1'b0, 4'd15);
    check("rel_end_level", int'(level), 0);
    check("rel_end_state", int'(state), 0);
    check("rel_end_busy", int'(busy), 0);
    check("rel_end_out", int'(sample_out), 0);

    // New note, then retrigger from RELEASE at level 100
    for (int i = 0; i < 81; i++) strobe(1'b1, 4'd15);
    strobe(1'b0, 4'd15);
    for (int i = 0; i < 60; i++) strobe(1'b0, 4'd15);
    check("pre_retrig_level", int'(level), 100);
    strobe(1'b1, 4'd15);
    check("retrig_state", int'(state), 1);
    check("retrig_level", int'(level), 100);
    strobe(1'b1, 4'd15);
    check("retrig_next", int'(level), 108);
    for (int i = 0; i < 19; i++) strobe(1'b1, 4'd15);
    check("retrig_top", int'(level), 255);

    // Strobe gating: gate toggles and samples change with ena low
    for (int i = 0; i < 20; i++) tick(1'b0, 1'(i), 4'($urandom_range(0, 15)));
    check("gated_level", int'(level), 255);
    check("gated_state", int'(state), 2);

    // Gate held through release, then reset mid-note
    for (int i = 0; i < 10; i++) strobe(1'b1, 4'd15);
    strobe(1'b0, 4'd15);
    for (int i = 0; i < 5; i++) strobe(1'b1, 4'd15);
    for (int i = 0; i < 5; i++) strobe(1'b1, 4'd15);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_state", int'(state), 0);
    check("mid_rst_level", int'(level), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_out", int'(sample_out), 0);
    m_state = 0;
    m_level = 0;
    m_gq = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) strobe(1'b0, 4'd7);
    @(negedge clock);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
